ac3_acc_writer: RTL

AC3_ACC_WRITER -- requirements
Module: ac3_acc_writer

---
 rtl/ac3_acc_writer.sv | 104 ++++++++++
 1 files changed

// File: rtl/ac3_acc_writer.sv
// ac3_acc_writer: four-lane partial-sum accumulator that drains lanes 0..3 in order on flush.
// Optional macro AC3_SAT_EN: signed saturation on accumulate instead of modulo-2^W wrap.
module ac3_acc_writer #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  localparam int W  = $clog2(M) + Pa + Pw + $clog2(MNO) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_clr,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic [3:0]   lane_dirty,
  output logic         busy
);

  typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0]          dirty_q, dirty_d;
  logic signed [W-1:0] lane_q [4];
  logic signed [W-1:0] lane_d [4];

  function automatic logic signed [W-1:0] acc_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef AC3_SAT_EN
    logic signed [W-1:0] s;
    s = a + b;
    // Overflow only when both operands share a sign the result does not.
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))
      s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s;
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirty_d = dirty_q;
    for (int k = 0; k < 4; k++) lane_d[k] = lane_q[k];

    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          lane_d[in_sel]  = in_clr ? $signed(in_data)
                                   : acc_add(lane_q[in_sel], $signed(in_data));
          dirty_d[in_sel] = 1'b1;
        end
        if (flush) begin
          state_d = ST_DRAIN;
          idx_d   = 2'd0;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          lane_d[idx_q]  = '0;
          dirty_d[idx_q] = 1'b0;
          if (idx_q == 2'd3) begin
            state_d = ST_ACCUM;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      idx_q   <= 2'd0;
      dirty_q <= 4'd0;
      for (int k = 0; k < 4; k++) lane_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      for (int k = 0; k < 4; k++) lane_q[k] <= lane_d[k];
    end
  end

  // Outputs are decoded straight from registers so reset clears them at once.
  assign in_ready   = (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_DRAIN);
  assign busy       = (state_q == ST_DRAIN);
  assign out_sel    = out_valid ? idx_q : 2'd0;
  assign out_data   = out_valid ? lane_q[idx_q] : '0;
  assign lane_dirty = dirty_q;

endmodule
